// File: rtl/acc_datapath.sv
// acc_datapath: accumulator-machine datapath with PC, IR, MDR, Acc, ALU and a unified memory
module acc_datapath #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          AccSrc,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          ldIR,
  input  logic          ldMDR,
  input  logic          ldAcc,
  input  logic          IorD,
  input  logic          Asrc,
  input  logic          PCsrc,
  input  logic          PCwrite,
  input  logic          jz,
  input  logic [1:0]    ALUop,
  input  logic [1:0]    Bsrc,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [2:0]    opcode,
  output logic          zero,
  output logic [DW-1:0] acc_out,
  output logic [AW-1:0] pc_out
);
  logic [AW-1:0] pc, mem_addr, pc_next;
  logic [DW-1:0] ir, mdr, acc, rdata, a, b, alu;
  logic [DW-1:0] mem [2**AW];
  assign mem_addr = IorD ? ir[AW-1:0] : pc;
  assign rdata    = mem[mem_addr];
  // Bench preload owns the write port when both writers collide
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (MemWrite) mem[mem_addr] <= acc;
  end
  always_comb begin
    a   = Asrc ? acc : DW'(pc);
    b   = (Bsrc == 2'b00) ? mdr : (Bsrc == 2'b01) ? DW'(1) : '0;
    alu = (ALUop == 2'b00) ? a + b : (ALUop == 2'b01) ? a - b : (ALUop == 2'b10) ? a & b : ~a;
  end
  assign zero    = (alu == '0);
  assign pc_next = PCsrc ? ir[AW-1:0] : alu[AW-1:0];
  // MemRead alone captures MDR so the decode state can fetch the operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= '0;
      ir  <= '0;
      mdr <= '0;
      acc <= '0;
    end else begin
      if (ldIR) ir <= rdata;
      if (ldMDR | MemRead) mdr <= rdata;
      if (ldAcc) acc <= AccSrc ? mdr : alu;
      if (PCwrite | (jz & zero)) pc <= pc_next;
    end
  end
  assign opcode  = ir[DW-1:DW-3];
  assign acc_out = acc;
  assign pc_out  = pc;
endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
- Multicycle accumulator-machine datapath sitting directly downstream of the accumulator CPU controller FSM (IF, ID, ADD, SUB, AND, NOT, LDA, STA, JMP, JZ).
- Consumes the controller's per-state control bits and returns the opcode to it.
- Contains the PC, IR, MDR and Acc registers, the ALU, the PC-next logic and a unified 32x8 instruction/data memory.
- Instruction format: IR[7:5] is the opcode, IR[4:0] is the memory address.

Parameters:
- AW, 5, memory address width and PC width.
- DW, 8, data, instruction and accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- AccSrc  in  1  Acc input select: 0 = ALU result, 1 = MDR.
- MemRead  in  1  memory read enable.
- MemWrite  in  1  memory write enable.
- ldIR  in  1  load IR from memory read data.
- ldMDR  in  1  load MDR from memory read data.
- ldAcc  in  1  load Acc.
- IorD  in  1  memory address select: 0 = PC, 1 = IR[4:0].
- Asrc  in  1  ALU A select: 0 = {3'b0,PC}, 1 = Acc.
- PCsrc  in  1  PC next select: 0 = ALU[4:0], 1 = IR[4:0].
- PCwrite  in  1  unconditional PC load.
- jz  in  1  conditional PC load, taken when zero=1.
- ALUop  in  2  00 add, 01 sub, 10 and, 11 not.
- Bsrc  in  2  ALU B select: 00 = MDR, 01 = 8'd1, 10/11 = 8'd0.
- ld_en  in  1  bench preload write enable.
- ld_addr  in  AW  preload address.
- ld_data  in  DW  preload data.
- opcode  out  3  IR[7:5], to the controller.
- zero  out  1  combinational: ALU result == 0.
- acc_out  out  DW  Acc value.
- pc_out  out  AW  PC value.

Behaviour:
- Reset: rst=0 immediately clears PC, IR, MDR and Acc to 0, so opcode, acc_out and pc_out are 0. This holds even mid-instruction.
- Memory contents are not affected by reset. Memory power-up contents are X; the bench must preload any location it reads.
- Memory address: mem_addr = IorD ? IR[4:0] : PC.
- Memory read: asynchronous (combinational), rdata = mem[mem_addr]. Reading with MemRead=0 has no side effect.
- Memory write: synchronous on the clk rising edge.
  - MemWrite=1 writes Acc to mem[mem_addr].
  - ld_en=1 writes ld_data to mem[ld_addr].
  - If ld_en and MemWrite are both 1, ld_en wins and the MemWrite is dropped.
- IR: on a rising edge with ldIR=1, IR <= rdata.
- MDR: on a rising edge with (ldMDR | MemRead)=1, MDR <= rdata. The ID state asserts only MemRead/IorD, so the operand must land in MDR on that condition.
- ALU:
  - A = Asrc ? Acc : {3'b0, PC}.
  - B is selected per Bsrc.
  - Result is 8-bit modulo 256, no carry or overflow. NOT ignores B and returns ~A.
- Acc: on a rising edge with ldAcc=1, Acc <= AccSrc ? MDR : alu.
- PC:
  - Load condition is PCwrite | (jz & zero).
  - Next value is PCsrc ? IR[4:0] : alu[4:0], with 5-bit wrap (31+1 -> 0).
  - If PCwrite=1 and jz=1, PC loads regardless of zero.
- Simultaneous loads use pre-edge values. Example: in IF, IR and MDR capture mem[old PC] and PC becomes old PC+1.
- Latency: all register updates take effect at the clocking edge. opcode is valid the cycle after IF.
- Per-state control vectors:
  - IF: PCwrite=1, Bsrc=01, ldIR=1, MemRead=1, all others 0.
  - ID: MemRead=1, IorD=1.
  - ADD: Asrc=1, Bsrc=00, ALUop=00, ldAcc=1, AccSrc=0. SUB and AND differ only in ALUop=01 / 10.
  - NOT: Asrc=1, ALUop=11, ldAcc=1, AccSrc=0.
  - LDA: ldAcc=1, AccSrc=1.
  - STA: MemWrite=1, IorD=1.
  - JMP: PCwrite=1, PCsrc=1.
  - JZ: Asrc=1, Bsrc=00, ALUop=01, jz=1, PCsrc=1.
- No X may propagate into the registers when controls are 0.

Test Plan:
- Reset mid-op: preload, run IF, then pulse rst=0 between edges -> PC, IR, MDR and Acc read 0 within the same cycle; mem[0] is unchanged.
- Fetch: mem[0]=8'h83, apply IF -> IR=8'h83, opcode=3'b100, pc_out=1. Then apply ID -> MDR=mem[3].
- LDA/ADD/SUB:
  - Start with mem[3]=8'h02, mem[4]=8'h05.
  - LDA 3 -> Acc=8'h02.
  - ADD 4 -> Acc=8'h07.
  - SUB 4 twice -> Acc=8'h02, then 8'hFD (wrap).
  - AND with 8'h0F -> 8'h0D; NOT -> 8'hF2.
- STA: Acc=8'h5A, IR=8'hBF, apply STA -> mem[31]=8'h5A. In the same cycle ld_en to addr 31 with 8'h11 -> mem[31]=8'h11 (ld_en wins).
- JMP/JZ:
  - JMP with IR=8'hDA -> PC=26.
  - JZ with Acc=MDR=8'h33 -> zero=1, PC=IR[4:0].
  - JZ with Acc=8'h33, MDR=8'h34 -> zero=0, PC unchanged.
- PC wrap: PC=31, apply IF -> PC=0, IR=mem[31].
